mdu_seq_ctrl: RTL and testbench

//  Sequencer for the iterative multiply/divide unit used by EX for mult/multu/div/divu.

---
 rtl/mdu_seq_ctrl_pkg.sv | 26 ++
 rtl/mdu_iter_dp.sv | 102 ++++++++++
 rtl/mdu_seq_ctrl.sv | 97 +++++++++
 tb/tb_mdu_seq_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_seq_ctrl_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer: operation codes,
// FSM states and small operation-decode helpers.
package mdu_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter_dp.sv
// Radix-2 iteration datapath: shift-add multiply or restoring divide on operand
// magnitudes, with sign pre-fixup on load and sign post-fixup on the result.
module mdu_iter_dp
  import mdu_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              load,
  input  logic              step,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                  input logic is_signed);
    logic signed [DATA_W-1:0] neg_v;
    neg_v = -v;
    return (is_signed && v[DATA_W-1]) ? $unsigned(neg_v) : $unsigned(v);
  endfunction

  function automatic logic [DATA_W-1:0] neg_narrow(input logic [DATA_W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg_wide(input logic [2*DATA_W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // acc_hi is the partial remainder (divide) or the running upper product (multiply);
  // acc_lo starts as dividend / multiplier and fills with quotient / lower product.
  logic [DATA_W:0]   acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0] opnd_q, raw_a_q;
  logic              is_div_q, neg_res_q, neg_rem_q, div_zero_q;

  logic              ld_signed, ld_div;
  logic [DATA_W-1:0] mag_a, mag_b;

  assign ld_signed = op_is_signed(op);
  assign ld_div    = op_is_div(op);
  assign mag_a     = magnitude(src_a, ld_signed);
  assign mag_b     = magnitude(src_b, ld_signed);

  always_ff @(posedge clk) begin
    if (load) begin
      acc_hi_q   <= '0;
      acc_lo_q   <= ld_div ? mag_a : mag_b;
      opnd_q     <= ld_div ? mag_b : mag_a;
      raw_a_q    <= src_a;
      is_div_q   <= ld_div;
      neg_res_q  <= ld_signed && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
      neg_rem_q  <= ld_signed && src_a[DATA_W-1];
      div_zero_q <= ld_div && (src_b == '0);
    end else if (step) begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
    end
  end

  logic [DATA_W-1:0] addend;
  logic [DATA_W:0]   sum, shifted, trial;
  logic              fits;

  always_comb begin
    addend  = acc_lo_q[0] ? opnd_q : '0;
    sum     = acc_hi_q + {1'b0, addend};
    shifted = {acc_hi_q[DATA_W-1:0], acc_lo_q[DATA_W-1]};
    trial   = shifted - {1'b0, opnd_q};
    fits    = shifted >= {1'b0, opnd_q};
    if (is_div_q) begin
      acc_hi_d = fits ? trial : shifted;
      acc_lo_d = {acc_lo_q[DATA_W-2:0], fits};
    end else begin
      acc_hi_d = {1'b0, sum[DATA_W:1]};
      acc_lo_d = {sum[0], acc_lo_q[DATA_W-1:1]};
    end
  end

  // Result of the iteration now in flight, sign-corrected; sampled by the
  // sequencer on the final iteration.
  logic [2*DATA_W-1:0] prod;

  always_comb begin
    prod   = neg_wide({acc_hi_d[DATA_W-1:0], acc_lo_d}, neg_res_q);
    res_hi = prod[2*DATA_W-1:DATA_W];
    res_lo = prod[DATA_W-1:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        res_hi = raw_a_q;
        res_lo = '1;
      end else begin
        res_hi = neg_narrow(acc_hi_d[DATA_W-1:0], neg_rem_q);
        res_lo = neg_narrow(acc_lo_d, neg_res_q);
      end
    end
  end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Multiply/divide sequencer for EX: FSM, iteration counter, EX stall request
// and the registered {hi,lo} result handshake toward WB.
module mdu_seq_ctrl
  import mdu_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stallreq_for_ex,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              load, step, cap, last_iter;
  logic [DATA_W-1:0] res_hi, res_lo;

  assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

  mdu_iter_dp #(
    .DATA_W(DATA_W)
  ) u_dp (
    .clk   (clk),
    .load  (load),
    .step  (step),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .res_hi(res_hi),
    .res_lo(res_lo)
  );

  always_comb begin
    state_d         = state_q;
    stallreq_for_ex = 1'b0;
    busy            = 1'b0;
    result_valid    = 1'b0;
    load            = 1'b0;
    step            = 1'b0;
    cap             = 1'b0;
    unique case (state_q)
      MDU_IDLE: begin
        // The stall must be combinational so the op never leaves EX.
        if (start && !flush) begin
          stallreq_for_ex = 1'b1;
          load            = 1'b1;
          state_d         = MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        stallreq_for_ex = 1'b1;
        busy            = 1'b1;
        step            = 1'b1;
        if (flush) begin
          state_d = MDU_IDLE;
        end else if (last_iter) begin
          cap     = 1'b1;
          state_d = MDU_DONE;
        end
      end
      MDU_DONE: begin
        result_valid = 1'b1;
        if (flush || !ex_hold) state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else begin
      state_q <= state_d;
      if (load)      cnt_q <= '0;
      else if (step) cnt_q <= cnt_q + CNT_W'(1);
      if (cap) begin
        hi_out <= res_hi;
        lo_out <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Bench for mdu_seq_ctrl: directed vector table, hand-written flush/hold/reset
// sequences and random operations checked against an arithmetic reference.
module tb_mdu_seq_ctrl;

  localparam logic [1:0] MULT  = 2'd0;
  localparam logic [1:0] MULTU = 2'd1;
  localparam logic [1:0] DIV   = 2'd2;
  localparam logic [1:0] DIVU  = 2'd3;

  logic        clk = 1'b0;
  logic        rst, start, flush, ex_hold;
  logic [1:0]  op_i;
  logic [31:0] src_a, src_b;
  logic        stallreq_for_ex, busy, result_valid;
  logic [31:0] hi_out, lo_out;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] prev_hi, prev_lo;

  mdu_seq_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .op             (op_i),
    .src_a          (src_a),
    .src_b          (src_b),
    .flush          (flush),
    .ex_hold        (ex_hold),
    .stallreq_for_ex(stallreq_for_ex),
    .busy           (busy),
    .result_valid   (result_valid),
    .hi_out         (hi_out),
    .lo_out         (lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; signed division truncates toward zero
  // so the remainder follows the dividend's sign.
  function automatic logic [63:0] ref_mdu(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      MULT:  p = 64'(sa * sb);
      MULTU: p = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) begin
          p = {a, 32'hFFFF_FFFF};
        end else if (op == DIV) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {a % b, a / b};
        end
      end
    endcase
    return p;
  endfunction

  // Starts an op in the current (IDLE) cycle, follows it to DONE, optionally
  // holds DONE with ex_hold, and leaves the DUT back in IDLE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int hold,
                        input string nm);
    int lat, stall_cnt, rv_cnt;
    bit seen;
    op_i = op; src_a = a; src_b = b; start = 1'b1; flush = 1'b0; ex_hold = 1'b0;
    #1;
    stall_cnt = stallreq_for_ex ? 1 : 0;
    lat = 0; seen = 0; rv_cnt = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (result_valid) seen = 1;
      else if (stallreq_for_ex && busy) stall_cnt++;
    end
    check({nm, " latency"}, 64'(lat), 64'd33);
    check({nm, " stall cycles"}, 64'(stall_cnt), 64'd33);
    check({nm, " done flags"}, {61'd0, result_valid, busy, stallreq_for_ex}, 64'b100);
    check({nm, " hi/lo"}, {hi_out, lo_out}, {eh, el});
    if (result_valid) rv_cnt = 1;
    for (int i = 0; i < hold; i++) begin
      ex_hold = 1'b1;
      @(posedge clk); #1;
      if (result_valid) rv_cnt++;
      check({nm, " held flags"}, {61'd0, result_valid, busy, stallreq_for_ex}, 64'b100);
      check({nm, " held hi/lo"}, {hi_out, lo_out}, {eh, el});
    end
    if (hold > 0) check({nm, " valid cycles"}, 64'(rv_cnt), 64'(hold + 1));
    ex_hold = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    check({nm, " back to idle"}, {61'd0, result_valid, busy, stallreq_for_ex}, 64'b000);
    prev_hi = eh;
    prev_lo = el;
  endtask

  initial begin
    logic [63:0] r;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          mode;

    vecs[0]  = '{MULTU, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE, "multu max*2"};
    vecs[1]  = '{MULT,  32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult -3*5"};
    vecs[2]  = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult min*min"};
    vecs[3]  = '{DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2"};
    vecs[4]  = '{DIVU,  32'h7,         32'h0,         32'h0000_0007, 32'hFFFF_FFFF, "divu 7/0"};
    vecs[5]  = '{DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu 100/7"};
    vecs[6]  = '{DIV,   32'h7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div 7/-2"};
    vecs[7]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div min/-1"};
    vecs[8]  = '{DIV,   32'hFFFF_FFF8, 32'h0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, "div -8/0"};
    vecs[9]  = '{MULT,  32'h8000_0000, 32'h1,         32'hFFFF_FFFF, 32'h8000_0000, "mult min*1"};
    vecs[10] = '{MULTU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "multu 2^31 sq"};
    vecs[11] = '{DIVU,  32'hFFFF_FFFF, 32'h1000_0000, 32'h0FFF_FFFF, 32'h0000_000F, "divu max/2^28"};

    rst = 1'b1; start = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    op_i = MULT; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset flags", {61'd0, result_valid, busy, stallreq_for_ex}, 64'b000);
    check("reset hi/lo", {hi_out, lo_out}, 64'd0);

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 0, vecs[i].name);

    // Flush during iteration 10, then a new op in the cycle right after.
    op_i = DIVU; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin
      check("pre-flush no valid", {63'd0, result_valid}, 64'd0);
      @(posedge clk); #1;
    end
    flush = 1'b1; start = 1'b0;
    #1;
    check("flush cycle busy", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("after flush flags", {61'd0, result_valid, busy, stallreq_for_ex}, 64'b000);
    check("after flush hi/lo held", {hi_out, lo_out}, {prev_hi, prev_lo});
    run_op(MULT, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, "post-flush mult");

    // flush and start together in IDLE: flush wins.
    op_i = MULTU; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
    #1;
    check("flush+start stall", {63'd0, stallreq_for_ex}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush+start stays idle", {62'd0, busy, result_valid}, 64'd0);

    // ex_hold for 3 cycles in DONE with start held.
    run_op(DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 3, "hold div");

    // Reset mid-BUSY, then a fresh divide.
    op_i = MULTU; src_a = 32'd12345; src_b = 32'd6789; start = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid reset flags", {61'd0, result_valid, busy, stallreq_for_ex}, 64'b000);
    check("mid reset hi/lo", {hi_out, lo_out}, 64'd0);
    run_op(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, "divu after reset");

    // Random operations against the reference model.
    for (int n = 0; n < 60; n++) begin
      rop  = 2'($urandom_range(0, 3));
      ra   = $urandom;
      rb   = $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: begin ra = $urandom_range(0, 40); rb = $urandom_range(1, 9); end
        4: rb = $urandom_range(1, 255);
        default: ;
      endcase
      r = ref_mdu(rop, ra, rb);
      run_op(rop, ra, rb, r[63:32], r[31:0], (n % 7 == 0) ? 2 : 0,
             $sformatf("rand%0d op%0d %h,%h", n, rop, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
